// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter FSM states,
// default byte width and a constant ceil(log2) helper.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: finds the first eligible bit
// starting just after ptr_i and wrapping, so ptr_i itself has lowest priority.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        elig_i,
    input  logic [clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]        win_o,
    output logic [clog2(NUM_REQ)-1:0] idx_o,
    output logic                      any_o
);

    localparam int IW = clog2(NUM_REQ);

    always_comb begin
        int            pos;
        logic [IW-1:0] pos_idx;
        logic          found;
        win_o   = '0;
        idx_o   = '0;
        pos     = 0;
        pos_idx = '0;
        found   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            pos     = (int'(ptr_i) + off) % NUM_REQ;
            pos_idx = IW'(pos);
            if (!found && elig_i[pos_idx]) begin
                found          = 1'b1;
                win_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources;
// issues one byte per grant and follows tx_busy until the frame completes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_BURST    = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_en,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        tx_wr,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [clog2(NUM_REQ)-1:0]   owner,
    output logic                        active,
    output logic                        timeout
);

    localparam int IW = clog2(NUM_REQ);
    localparam int BW = clog2(MAX_BURST + 1);
    localparam int TW = clog2(BUSY_TIMEOUT + 1);

    arb_state_e          state_q,   state_d;
    logic [BW-1:0]       burst_q,   burst_d;
    logic [TW-1:0]       timer_q,   timer_d;
    logic [NUM_REQ-1:0]  gnt_q,     gnt_d;
    logic                tx_wr_q,   tx_wr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [IW-1:0]       owner_q,   owner_d;
    logic                active_q,  active_d;
    logic                timeout_q, timeout_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  pick_win;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                keep_owner;

    assign eligible = req & req_en;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .elig_i (eligible),
        .ptr_i  (owner_q),
        .win_o  (pick_win),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // burst_q == 0 means no burst is open (after reset or a timeout), so the
    // previous owner gets no continuation and rotation starts after it.
    assign keep_owner = req[owner_q] && req_en[owner_q] &&
                        (burst_q != '0) && (burst_q < BW'(MAX_BURST));

    always_comb begin
        logic [IW-1:0] win_idx;
        state_d   = state_q;
        burst_d   = burst_q;
        timer_d   = timer_q;
        gnt_d     = '0;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        owner_d   = owner_q;
        active_d  = active_q;
        timeout_d = 1'b0;
        win_idx   = owner_q;

        case (state_q)
            IDLE: begin
                if (!tx_busy && pick_any) begin
                    if (keep_owner) begin
                        win_idx = owner_q;
                        gnt_d   = NUM_REQ'(1) << owner_q;
                        burst_d = burst_q + BW'(1);
                    end else begin
                        win_idx = pick_idx;
                        gnt_d   = pick_win;
                        burst_d = BW'(1);
                    end
                    tx_wr_d   = 1'b1;
                    tx_data_d = req_data[int'(win_idx)*DATA_W +: DATA_W];
                    owner_d   = win_idx;
                    active_d  = 1'b1;
                    timer_d   = '0;
                    state_d   = WAIT_BUSY;
                end
            end

            WAIT_BUSY: begin
                // busy wins over an expiring timer in the same cycle
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    burst_d   = '0;
                    active_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            timer_q   <= '0;
            gnt_q     <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
            owner_q   <= IW'(NUM_REQ - 1);
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            owner_q   <= owner_d;
            active_q  <= active_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;
    assign owner   = owner_q;
    assign active  = active_q;
    assign timeout = timeout_q;

endmodule
